// File: rtl/pipelined_alu_core.sv
// pipelined_alu_core: parametrised ALU evaluated in stage 0, followed by pure-delay stages
// with valid/ready flow control, bubble collapsing and registered carry/zero flags.
module pipelined_alu_core #(
   parameter int WIDTH    = 32,
   parameter int DATABITS = 7,
   parameter int STAGES   = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2:0]          in_op,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic [DATABITS-1:0] in_databits,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2:0]          out_op,
   output logic [WIDTH-1:0]    res,
   output logic [DATABITS-1:0] out_databits,
   output logic                carry,
   output logic                zero
);
   localparam int PW = 3 + WIDTH + DATABITS + 2;
   logic [STAGES-1:0]  r_valid;
   logic [PW-1:0]      r_pay [STAGES];
   logic [STAGES-1:0]  w_ready;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_res;
   logic               w_carry;
   logic [PW-1:0]      w_eval;
   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_diff = {1'b0, a} - {1'b0, b};
   assign w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      case (in_op)
         3'd1: {w_carry, w_res} = w_sum;
         3'd2: {w_carry, w_res} = w_diff;
         3'd3: begin
            w_res   = w_prod[WIDTH-1:0];
            w_carry = |w_prod[2*WIDTH-1:WIDTH];
         end
         3'd4: w_res = a & b;
         3'd5: w_res = a | b;
         3'd6: w_res = a ^ b;
         3'd7: w_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         default: ;
      endcase
   end
   assign w_eval = {in_op, w_res, in_databits, w_carry, w_res == '0};
   // Unrolled ready chain: a stage can move if any stage at or after it is empty.
   for (genvar i = 0; i < STAGES; i++) begin : g_rdy
      assign w_ready[i] = out_ready || !(&r_valid[STAGES-1:i]);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         for (int k = 0; k < STAGES; k++) r_pay[k] <= '0;
      end else begin
         if (w_ready[0]) begin
            r_valid[0] <= in_valid;
            if (in_valid) r_pay[0] <= w_eval;
         end
         for (int k = 1; k < STAGES; k++) begin
            if (w_ready[k]) begin
               r_valid[k] <= r_valid[k-1];
               if (r_valid[k-1]) r_pay[k] <= r_pay[k-1];
            end
         end
      end
   end
   assign in_ready  = w_ready[0];
   assign out_valid = r_valid[STAGES-1];
   assign {out_op, res, out_databits, carry, zero} = r_pay[STAGES-1];
endmodule

// File: tb/tb_pipelined_alu_core.sv
// tb_pipelined_alu_core: randomized and directed checks of the pipelined ALU against a
// queue-based reference model of accepted operations.
module tb_pipelined_alu_core;
   typedef logic [43:0] rec_t;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [6:0]  in_databits = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [2:0]  out_op;
   logic [31:0] res;
   logic [6:0]  out_databits;
   logic        carry;
   logic        zero;
   rec_t exp_q[$];
   rec_t got_q[$];
   int   acc_cyc[$];
   int   got_cyc[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   pipelined_alu_core #(.WIDTH(32), .DATABITS(7), .STAGES(3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .a(a), .b(b), .in_databits(in_databits), .out_valid(out_valid), .out_ready(out_ready),
      .out_op(out_op), .res(res), .out_databits(out_databits), .carry(carry), .zero(zero)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic rec_t model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic [6:0] t);
      logic [63:0] w;
      logic [31:0] r;
      logic c;
      r = '0;
      c = 1'b0;
      case (op)
         3'd1: begin w = 64'(x) + 64'(y); r = w[31:0]; c = w[32]; end
         3'd2: begin r = x - y; c = x < y; end
         3'd3: begin w = 64'(x) * 64'(y); r = w[31:0]; c = w[63:32] != 0; end
         3'd4: r = x & y;
         3'd5: r = x | y;
         3'd6: r = x ^ y;
         3'd7: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         default: ;
      endcase
      return {op, r, t, c, r == 32'd0};
   endfunction

   function automatic logic [31:0] rval();
      int s;
      s = $urandom_range(0, 3);
      return s == 0 ? 32'd0 : s == 1 ? 32'hFFFFFFFF : s == 2 ? 32'($urandom_range(0, 15)) : 32'($urandom);
   endfunction

   task automatic rand_in();
      in_op       = 3'($urandom_range(0, 7));
      a           = rval();
      b           = rval();
      in_databits = 7'($urandom);
   endtask

   task automatic cycle();
      @(negedge clk);
      cyc++;
      if (reset) begin
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_op, a, b, in_databits));
            acc_cyc.push_back(cyc);
         end
         if (out_valid && out_ready) begin
            got_q.push_back({out_op, res, out_databits, carry, zero});
            got_cyc.push_back(cyc);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      exp_q.delete();
      got_q.delete();
      acc_cyc.delete();
      got_cyc.delete();
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) cycle();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      n_chk++;
      if ({out_valid, out_op, res, out_databits, carry, zero} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b op=%0d res=%h tag=%h c=%b z=%b, want all 0",
                  out_valid, out_op, res, out_databits, carry, zero);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b, want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      rec_t want [3];
      clear();
      out_ready   = 1'b1;
      in_valid    = 1'b1;
      in_op       = 3'd1;
      a           = 32'hFFFFFFFF;
      b           = 32'd1;
      in_databits = 7'h15;
      cycle();
      drain();
      n_chk++;
      if (got_q.size() != 1) begin
         n_fail++;
         $display("FAIL add_count: got %0d results, want 1", got_q.size());
      end else begin
         n_chk++;
         if (got_q[0] !== {3'd1, 32'h0, 7'h15, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL add_wrap: got %h, want %h", got_q[0], {3'd1, 32'h0, 7'h15, 1'b1, 1'b1});
         end
         n_chk++;
         if (got_cyc[0] - acc_cyc[0] != 3) begin
            n_fail++;
            $display("FAIL add_latency: got %0d cycles, want 3", got_cyc[0] - acc_cyc[0]);
         end
      end
      clear();
      want[0] = {3'd2, 32'hFFFFFFFE, 7'd1, 1'b1, 1'b0};
      want[1] = {3'd3, 32'h0, 7'd2, 1'b1, 1'b1};
      want[2] = {3'd7, 32'h1, 7'd3, 1'b0, 1'b0};
      in_valid = 1'b1;
      in_op = 3'd2; a = 32'd3;          b = 32'd5;          in_databits = 7'd1; cycle();
      in_op = 3'd3; a = 32'h00010000;   b = 32'h00010000;   in_databits = 7'd2; cycle();
      in_op = 3'd7; a = 32'hFFFFFFFF;   b = 32'd1;          in_databits = 7'd3; cycle();
      drain();
      n_chk++;
      if (got_q.size() != 3) begin
         n_fail++;
         $display("FAIL sub_mult_slt_count: got %0d results, want 3", got_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (got_q[k] !== want[k]) begin
               n_fail++;
               $display("FAIL sub_mult_slt[%0d]: got %h, want %h", k, got_q[k], want[k]);
            end
         end
      end
   endtask

   task automatic test_stream();
      clear();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 10; k++) begin
         rand_in();
         cycle();
      end
      drain();
      n_chk++;
      if (acc_cyc.size() != 10 || got_q.size() != 10) begin
         n_fail++;
         $display("FAIL stream_count: got %0d accepted %0d results, want 10 and 10", acc_cyc.size(), got_q.size());
      end else begin
         n_chk++;
         if (got_cyc[9] - got_cyc[0] != 9) begin
            n_fail++;
            $display("FAIL stream_throughput: got span %0d cycles, want 9", got_cyc[9] - got_cyc[0]);
         end
         for (int k = 0; k < 10; k++) begin
            n_chk++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++;
               $display("FAIL stream_data[%0d]: got %h, want %h", k, got_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_back_pressure();
      logic [44:0] snap;
      clear();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         rand_in();
         cycle();
      end
      n_chk++;
      if (acc_cyc.size() != 3 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_capacity: got %0d accepted in_ready=%b, want 3 and 0", acc_cyc.size(), in_ready);
      end
      snap = {out_valid, out_op, res, out_databits, carry, zero};
      for (int k = 0; k < 4; k++) begin
         rand_in();
         cycle();
         n_chk++;
         if ({out_valid, out_op, res, out_databits, carry, zero} !== snap || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_stable[%0d]: got %h, want %h with valid", k,
                     {out_valid, out_op, res, out_databits, carry, zero}, snap);
         end
      end
      drain();
      n_chk++;
      if (got_q.size() != exp_q.size() || got_q.size() != 3) begin
         n_fail++;
         $display("FAIL stall_count: got %0d results, want %0d", got_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++;
               $display("FAIL stall_order[%0d]: got %h, want %h", k, got_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_gapped();
      clear();
      out_ready = 1'b0;
      for (int k = 0; k < 12; k++) begin
         in_valid = (k % 3 == 0);
         rand_in();
         cycle();
      end
      n_chk++;
      if (acc_cyc.size() != 3) begin
         n_fail++;
         $display("FAIL gapped_collapse: got %0d accepted, want 3", acc_cyc.size());
      end
      n_chk++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL gapped_full: got in_ready=%b, want 0", in_ready);
      end
      drain();
      n_chk++;
      if (got_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL gapped_count: got %0d results, want %0d", got_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < got_q.size(); k++) begin
            n_chk++;
            if (got_q[k] !== exp_q[k]) begin
               n_fail++;
               $display("FAIL gapped_order[%0d]: got %h, want %h", k, got_q[k], exp_q[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      clear();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op = 3'd1; a = 32'd5; b = 32'd6; in_databits = 7'h2A; cycle();
      in_op = 3'd5; a = 32'hF0; b = 32'h0F; in_databits = 7'h11; cycle();
      in_valid = 1'b0;
      cycle();
      n_chk++;
      if (out_valid !== 1'b1 || res !== 32'd11) begin
         n_fail++;
         $display("FAIL pre_reset: got valid=%b res=%h, want 1 and 0000000b", out_valid, res);
      end
      #2;
      reset = 1'b0;
      #1;
      n_chk++;
      if ({out_valid, out_op, res, out_databits, carry, zero} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got valid=%b op=%0d res=%h tag=%h c=%b z=%b, want all 0",
                  out_valid, out_op, res, out_databits, carry, zero);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      clear();
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) cycle();
      n_chk++;
      if (got_q.size() != 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stale_after_reset: got %0d results valid=%b, want 0 and 0", got_q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stream();
      test_back_pressure();
      test_gapped();
      test_reset_mid_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
